// File: rtl/parking_pkg.sv
// Shared types for the parking access controller: FSM states, lane index,
// and a lane-to-one-hot helper.
package parking_pkg;

  localparam int NUM_LANES = 2;
  localparam int LANE_W    = 1;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  function automatic logic [NUM_LANES-1:0] lane_mask(input lane_t lane);
    logic [NUM_LANES-1:0] m;
    m = '0;
    m[lane] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/parking_access_ctrl_rr_arb2.sv
// Two-lane round-robin arbiter. Under contention the lane that did not win
// last time is picked; the memory only moves when the grant is taken.
module rr_arb2
  import parking_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] req,
  input  logic                 take,
  output logic                 gnt_lane
);

  lane_t last_q;
  lane_t pick;

  always_comb begin
    pick = last_q;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_q;
      default: pick = last_q;
    endcase
  end

  assign gnt_lane = pick;

  // Reset value of lane 1 hands the first contention to lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_q <= 1'b1;
    else if (take) last_q <= pick;
  end

endmodule

// File: rtl/parking_access_ctrl.sv
// Two-lane parking gate controller: one outstanding grant at a time, gate
// timeout, saturating occupancy counter and misuse (violation) reporting.
module parking_access_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY  = 100,
  parameter int CNT_W     = 7,
  parameter int GATE_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       enter_pulse,
  input  logic             exit_pulse,
  output logic [1:0]       gate_open,
  output logic [1:0]       reject,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             violation
);

  localparam int HOLD_W = $clog2(GATE_HOLD + 1);
  localparam int SUM_W  = CNT_W + 2;

  state_t            state, state_nxt;
  lane_t             grant_lane, lane_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [1:0]        gate_nxt, reject_nxt;
  logic [CNT_W-1:0]  occ_nxt;
  logic              viol_nxt;
  logic              arb_take;
  logic              arb_lane;

  assign full  = (occupancy == CNT_W'(CAPACITY));
  assign empty = (occupancy == '0);

  assign arb_take = (state == IDLE) && (|req) && !full;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .take     (arb_take),
    .gnt_lane (arb_lane)
  );

  // Grant FSM: gate and reject are registered from the next-state decode.
  always_comb begin
    state_nxt  = state;
    lane_nxt   = grant_lane;
    hold_nxt   = hold_cnt;
    gate_nxt   = '0;
    reject_nxt = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          if (full) begin
            reject_nxt = req;
          end else begin
            state_nxt = GRANT;
            lane_nxt  = arb_lane;
            hold_nxt  = '0;
            gate_nxt  = lane_mask(arb_lane);
          end
        end
      end
      GRANT: begin
        if (enter_pulse[grant_lane] || hold_cnt == HOLD_W'(GATE_HOLD - 1)) begin
          state_nxt = COOLDOWN;
          hold_nxt  = '0;
        end else begin
          gate_nxt = lane_mask(grant_lane);
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      COOLDOWN: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Occupancy: every enter counts (granted or not); exits only when non-empty.
  logic [1:0]       granted, tailgate;
  logic [SUM_W-1:0] inc, dec, sum;

  always_comb begin
    granted  = (state == GRANT) ? lane_mask(grant_lane) : 2'b00;
    tailgate = enter_pulse & ~granted;
    inc      = SUM_W'(enter_pulse[0]) + SUM_W'(enter_pulse[1]);
    dec      = SUM_W'(exit_pulse && !empty);
    sum      = SUM_W'(occupancy) + inc - dec;
    occ_nxt  = (sum > SUM_W'(CAPACITY)) ? CNT_W'(CAPACITY) : sum[CNT_W-1:0];
    viol_nxt = (|tailgate) || (exit_pulse && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_lane <= '0;
      hold_cnt   <= '0;
      gate_open  <= '0;
      reject     <= '0;
      violation  <= 1'b0;
      occupancy  <= '0;
    end else begin
      state      <= state_nxt;
      grant_lane <= lane_nxt;
      hold_cnt   <= hold_nxt;
      gate_open  <= gate_nxt;
      reject     <= reject_nxt;
      violation  <= viol_nxt;
      occupancy  <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_parking_access_ctrl.sv
// Bench for parking_access_ctrl: directed table, hand-written corner
// sequences and a randomized run against a reference model.
module tb_parking_access_ctrl;

  localparam int CAP  = 4;
  localparam int HOLD = 8;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = '0, enter_pulse = '0;
  logic          exit_pulse = 1'b0;
  logic [1:0]    gate_open, reject;
  logic [CW-1:0] occupancy;
  logic          full, empty, violation;

  parking_access_ctrl #(.CAPACITY(CAP), .CNT_W(CW), .GATE_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .enter_pulse(enter_pulse),
    .exit_pulse(exit_pulse), .gate_open(gate_open), .reject(reject),
    .occupancy(occupancy), .full(full), .empty(empty), .violation(violation)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] r, e;
    logic       x;
    logic [1:0] g, rj;
    int         occ;
    logic       v;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] g, input logic [1:0] rj,
                         input int occ, input logic v);
    chk({tag, ".gate"}, 32'(gate_open), 32'(g));
    chk({tag, ".reject"}, 32'(reject), 32'(rj));
    chk({tag, ".occ"}, 32'(occupancy), 32'(occ));
    chk({tag, ".viol"}, 32'(violation), 32'(v));
    chk({tag, ".full"}, 32'(full), 32'(occ == CAP));
    chk({tag, ".empty"}, 32'(empty), 32'(occ == 0));
  endtask

  // Inputs are applied just after an edge and held through the next one.
  task automatic step(input logic [1:0] r, input logic [1:0] e, input logic x);
    req = r; enter_pulse = e; exit_pulse = x;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; enter_pulse = '0; exit_pulse = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // Reference model state
  int m_st, m_lane, m_last, m_tg, m_occ;
  int inc, dec, nocc;
  logic mv;
  logic [1:0] mrj, mg, r, e;
  logic x;

  initial begin
    // Reset state
    #12;
    chk_all("reset", 2'b00, 2'b00, 0, 1'b0);
    rst_n = 1'b1;

    // Single-lane grant, entry, cooldown, exits and exit-at-empty
    tbl[0]  = '{2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 0, 1'b0};
    tbl[1]  = '{2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 0, 1'b0};
    tbl[2]  = '{2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 0, 1'b0};
    tbl[3]  = '{2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 1, 1'b0};
    tbl[4]  = '{2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1, 1'b0};
    tbl[5]  = '{2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 1, 1'b0};
    tbl[6]  = '{2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2, 1'b0};
    tbl[7]  = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1, 1'b0};
    tbl[8]  = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 0, 1'b0};
    tbl[9]  = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 0, 1'b1};
    tbl[10] = '{2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].x);
      chk_all($sformatf("tbl%0d", i), tbl[i].g, tbl[i].rj, tbl[i].occ, tbl[i].v);
    end

    // Contention alternates 0,1,0,1 then the full lot rejects both lanes
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 2'b00, 1'b0);
      chk_all($sformatf("rr%0d.grant", k), (k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, k, 1'b0);
      step(2'b11, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
      chk_all($sformatf("rr%0d.enter", k), 2'b00, 2'b00, k + 1, 1'b0);
      step(2'b11, 2'b00, 1'b0);
      chk_all($sformatf("rr%0d.cool", k), 2'b00, 2'b00, k + 1, 1'b0);
    end
    step(2'b11, 2'b00, 1'b0);
    chk_all("full.rej0", 2'b00, 2'b11, 4, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    chk_all("full.rej1", 2'b00, 2'b11, 4, 1'b0);

    // Tailgate at full saturates
    step(2'b00, 2'b10, 1'b0);
    chk_all("tailgate.full", 2'b00, 2'b00, 4, 1'b1);
    step(2'b00, 2'b00, 1'b1);
    chk_all("exit.a", 2'b00, 2'b00, 3, 1'b0);
    step(2'b00, 2'b00, 1'b1);
    chk_all("exit.b", 2'b00, 2'b00, 2, 1'b0);

    // Granted entry and exit in the same cycle
    step(2'b01, 2'b00, 1'b0);
    chk_all("netzero.grant", 2'b01, 2'b00, 2, 1'b0);
    step(2'b00, 2'b01, 1'b1);
    chk_all("netzero.both", 2'b00, 2'b00, 2, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    // Gate timeout: open exactly HOLD cycles
    step(2'b10, 2'b00, 1'b0);
    chk_all("hold.c1", 2'b10, 2'b00, 2, 1'b0);
    for (int i = 2; i <= HOLD; i++) begin
      step(2'b00, 2'b00, 1'b0);
      chk($sformatf("hold.c%0d", i), 32'(gate_open), 32'(2'b10));
    end
    step(2'b00, 2'b00, 1'b0);
    chk_all("hold.closed", 2'b00, 2'b00, 2, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    // Asynchronous reset mid-grant at occupancy 3
    step(2'b00, 2'b01, 1'b0);
    chk_all("pre.tailgate", 2'b00, 2'b00, 3, 1'b1);
    step(2'b01, 2'b00, 1'b0);
    chk_all("pre.grant", 2'b01, 2'b00, 3, 1'b0);
    req = 2'b00;
    #2 rst_n = 1'b0;
    #1 chk_all("rst.async", 2'b00, 2'b00, 0, 1'b0);
    #2 rst_n = 1'b1;
    step(2'b00, 2'b00, 1'b0);
    chk_all("rst.after", 2'b00, 2'b00, 0, 1'b0);

    // Randomized run against the reference model
    do_reset();
    m_st = 0; m_lane = 0; m_last = 1; m_tg = 0; m_occ = 0;
    for (int n = 0; n < 3000; n++) begin
      r = 2'($urandom_range(0, 3));
      e = 2'b00;
      if (m_st == 1 && $urandom_range(0, 3) == 0) e[m_lane] = 1'b1;
      if ($urandom_range(0, 24) == 0) e[$urandom_range(0, 1)] = 1'b1;
      x = ($urandom_range(0, 4) == 0);

      mv  = 1'b0;
      inc = int'(e[0]) + int'(e[1]);
      for (int i = 0; i < 2; i++)
        if (e[i] && !(m_st == 1 && m_lane == i)) mv = 1'b1;
      dec = (x && m_occ > 0) ? 1 : 0;
      if (x && m_occ == 0) mv = 1'b1;
      nocc = m_occ + inc - dec;
      if (nocc > CAP) nocc = CAP;
      mrj = 2'b00;
      case (m_st)
        0: if (r != 0) begin
             if (m_occ == CAP) mrj = r;
             else begin
               m_lane = (r == 3) ? 1 - m_last : ((r == 2) ? 1 : 0);
               m_last = m_lane;
               m_st   = 1;
               m_tg   = n;
             end
           end
        1: if (e[m_lane] || n - m_tg == HOLD) m_st = 2;
        default: m_st = 0;
      endcase
      m_occ = nocc;
      mg = (m_st == 1) ? ((m_lane == 1) ? 2'b10 : 2'b01) : 2'b00;

      step(r, e, x);
      chk_all($sformatf("rnd%0d", n), mg, mrj, m_occ, mv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
